mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/calculator_pkg.sv | 5 +
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/calculator_pkg.sv
// Shared sizing constants for the calculator datapath and its memory.
package calculator_pkg;
  localparam int ADDR_W        = 8;
  localparam int MEM_WORD_SIZE = 16;
endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin with burst locking, one-cycle read return.
// Optional contention counters are built only when MEM_ARBITER_PERF_CNT_EN is defined.
module mem_arbiter
  import calculator_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req0_i,
  input  logic                     we0_i,
  input  logic [ADDR_W-1:0]        addr0_i,
  input  logic [MEM_WORD_SIZE-1:0] wdata0_i,
  input  logic                     lock0_i,
  input  logic                     req1_i,
  input  logic                     we1_i,
  input  logic [ADDR_W-1:0]        addr1_i,
  input  logic [MEM_WORD_SIZE-1:0] wdata1_i,
  input  logic                     lock1_i,
  output logic                     gnt0_o,
  output logic                     gnt1_o,
  output logic                     rvalid0_o,
  output logic                     rvalid1_o,
  output logic [MEM_WORD_SIZE-1:0] rdata_o,
  output logic                     mem_write_o,
  output logic                     mem_read_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [MEM_WORD_SIZE-1:0] mem_wdata_o,
  input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
  output logic [15:0]              wait_cnt0_o,
  output logic [15:0]              wait_cnt1_o,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {
    S_RR    = 2'd0,
    S_LOCK0 = 2'd1,
    S_LOCK1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q;
  logic   pend_valid_q, pend_id_q;
  logic   pend_valid_d;

  // Handshake: reqN is a request held by the requester; gntN in the same cycle
  // means the access (read or write) was accepted, so the requester may change
  // its request fields at the next edge. Read data comes back as rvalidN one
  // cycle later with no backpressure.

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_RR;
      last_q       <= 1'b1;
      pend_valid_q <= 1'b0;
      pend_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      if (gnt0_o) begin
        last_q    <= 1'b0;
        pend_id_q <= 1'b0;
      end else if (gnt1_o) begin
        last_q    <= 1'b1;
        pend_id_q <= 1'b1;
      end
    end
  end

  always_comb begin
    gnt0_o  = 1'b0;
    gnt1_o  = 1'b0;
    state_d = state_q;
    unique case (state_q)
      S_RR: begin
        if (req0_i && req1_i) begin
          gnt1_o = (last_q == 1'b0);
          gnt0_o = (last_q == 1'b1);
        end else begin
          gnt0_o = req0_i;
          gnt1_o = req1_i;
        end
        // Only the round-robin winner can claim the lock.
        if (gnt0_o && lock0_i) state_d = S_LOCK0;
        else if (gnt1_o && lock1_i) state_d = S_LOCK1;
      end
      S_LOCK0: begin
        gnt0_o = req0_i;
        if (!req0_i || !lock0_i) state_d = S_RR;
      end
      S_LOCK1: begin
        gnt1_o = req1_i;
        if (!req1_i || !lock1_i) state_d = S_RR;
      end
      default: state_d = S_RR;
    endcase
  end

  always_comb begin
    mem_write_o  = 1'b0;
    mem_read_o   = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    pend_valid_d = 1'b0;
    if (gnt0_o) begin
      mem_write_o  = we0_i;
      mem_read_o   = !we0_i;
      mem_addr_o   = addr0_i;
      mem_wdata_o  = wdata0_i;
      pend_valid_d = !we0_i;
    end else if (gnt1_o) begin
      mem_write_o  = we1_i;
      mem_read_o   = !we1_i;
      mem_addr_o   = addr1_i;
      mem_wdata_o  = wdata1_i;
      pend_valid_d = !we1_i;
    end
  end

  assign rvalid0_o = pend_valid_q && (pend_id_q == 1'b0);
  assign rvalid1_o = pend_valid_q && (pend_id_q == 1'b1);
  assign rdata_o   = pend_valid_q ? mem_rdata_i : '0;
  assign state_o   = state_q;

`ifdef MEM_ARBITER_PERF_CNT_EN
  logic [15:0] wait_cnt0_q, wait_cnt1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt0_q <= '0;
      wait_cnt1_q <= '0;
    end else begin
      if (req0_i && !gnt0_o && (wait_cnt0_q != 16'hFFFF)) wait_cnt0_q <= wait_cnt0_q + 16'd1;
      if (req1_i && !gnt1_o && (wait_cnt1_q != 16'hFFFF)) wait_cnt1_q <= wait_cnt1_q + 16'd1;
    end
  end

  assign wait_cnt0_o = wait_cnt0_q;
  assign wait_cnt1_o = wait_cnt1_q;
`else
  assign wait_cnt0_o = '0;
  assign wait_cnt1_o = '0;
`endif

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) !(gnt0_o && gnt1_o));
  a_gnt0_req:   assert property (@(posedge clk_i) disable iff (!rst_ni) gnt0_o |-> req0_i);
  a_gnt1_req:   assert property (@(posedge clk_i) disable iff (!rst_ni) gnt1_o |-> req1_i);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small memory model plus hand-computed expectations.
module tb_mem_arbiter;
  import calculator_pkg::*;

`ifdef MEM_ARBITER_PERF_CNT_EN
  localparam logic [15:0] EXP_WAIT = 16'd2;
`else
  localparam logic [15:0] EXP_WAIT = 16'd0;
`endif

  logic                     clk, rst_n;
  logic                     req0, we0, lock0, req1, we1, lock1;
  logic [ADDR_W-1:0]        addr0, addr1;
  logic [MEM_WORD_SIZE-1:0] wdata0, wdata1;
  logic                     gnt0, gnt1, rvalid0, rvalid1;
  logic [MEM_WORD_SIZE-1:0] rdata, mem_wdata, mem_rdata;
  logic                     mem_write, mem_read;
  logic [ADDR_W-1:0]        mem_addr;
  logic [15:0]              wait_cnt0, wait_cnt1;
  logic [1:0]               state;

  logic [MEM_WORD_SIZE-1:0] mem_model [256];
  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0), .lock0_i(lock0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1), .lock1_i(lock1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata_o(rdata), .mem_write_o(mem_write), .mem_read_o(mem_read),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .wait_cnt0_o(wait_cnt0), .wait_cnt1_o(wait_cnt1), .state_o(state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Memory model: read data registered one cycle after the read strobe
  always @(posedge clk) begin
    if (mem_write) mem_model[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem_model[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive0(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [MEM_WORD_SIZE-1:0] d, input logic l);
    req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = l;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [MEM_WORD_SIZE-1:0] d, input logic l);
    req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = l;
  endtask

  task automatic idle();
    drive0(1'b0, 1'b0, '0, '0, 1'b0);
    drive1(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_state", state, 32'd0);
    check("rst_rvalid", {rvalid1, rvalid0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = '0;
    mem_model[8'h05] = 16'hABCD;
    mem_model[8'h30] = 16'h1111;
    mem_model[8'h31] = 16'h2222;
    mem_rdata = '0;
    rst_n = 1'b0;
    idle();
    #2;
    check("reset_state", state, 32'd0);
    check("reset_rvalid", {rvalid1, rvalid0}, 32'd0);
    check("reset_gnt", {gnt1, gnt0}, 32'd0);
    check("reset_strobes", {mem_write, mem_read}, 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_wait0", wait_cnt0, 32'd0);
    check("reset_wait1", wait_cnt1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read
    @(negedge clk);
    drive0(1'b1, 1'b0, 8'h05, '0, 1'b0);
    #1;
    check("rd_gnt", {gnt1, gnt0}, 32'b01);
    check("rd_strobes", {mem_write, mem_read}, 32'b01);
    check("rd_addr", mem_addr, 32'h05);
    @(negedge clk);
    idle();
    #1;
    check("rd_rvalid", {rvalid1, rvalid0}, 32'b01);
    check("rd_rdata", rdata, 32'hABCD);
    check("idle_strobes", {mem_write, mem_read}, 32'd0);
    check("idle_addr", mem_addr, 32'd0);
    check("idle_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    #1;
    check("rd_rvalid_drop", {rvalid1, rvalid0}, 32'd0);
    check("rd_rdata_zero", rdata, 32'd0);

    // Contention after reset: 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive0(1'b1, 1'b1, 8'h20, 16'h0A0A, 1'b0);
      drive1(1'b1, 1'b1, 8'h21, 16'h0B0B, 1'b0);
      #1;
      check("rr_gnt", {gnt1, gnt0}, (i % 2 == 0) ? 32'b01 : 32'b10);
    end
    @(negedge clk);
    idle();
    #1;
    check("rr_wait0", wait_cnt0, {16'd0, EXP_WAIT});
    check("rr_wait1", wait_cnt1, {16'd0, EXP_WAIT});

    // Lock: make last grant 0 so requester 1 wins the next contention
    @(negedge clk);
    drive0(1'b1, 1'b1, 8'h40, 16'h0001, 1'b0);
    #1;
    check("pre_lock_gnt", {gnt1, gnt0}, 32'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive0(1'b1, 1'b1, 8'h40, 16'h0001, 1'b0);
      drive1(1'b1, 1'b1, 8'h41, 16'h0002, 1'b1);
      #1;
      check("lock_gnt", {gnt1, gnt0}, 32'b10);
      check("lock_state", state, (i == 0) ? 32'd0 : 32'd2);
    end
    @(negedge clk);
    drive1(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    check("lock_drop_gnt", {gnt1, gnt0}, 32'b00);
    check("lock_drop_state", state, 32'd2);
    @(negedge clk);
    #1;
    check("unlock_gnt", {gnt1, gnt0}, 32'b01);
    check("unlock_state", state, 32'd0);

    // Interleaved write by 1 then read by 0
    @(negedge clk);
    idle();
    drive1(1'b1, 1'b1, 8'h10, 16'h1234, 1'b0);
    #1;
    check("wr_gnt", {gnt1, gnt0}, 32'b10);
    check("wr_strobes", {mem_write, mem_read}, 32'b10);
    check("wr_addr", mem_addr, 32'h10);
    check("wr_wdata", mem_wdata, 32'h1234);
    @(negedge clk);
    idle();
    drive0(1'b1, 1'b0, 8'h10, '0, 1'b0);
    #1;
    check("wr_no_rvalid", {rvalid1, rvalid0}, 32'd0);
    check("rdback_gnt", {gnt1, gnt0}, 32'b01);
    @(negedge clk);
    idle();
    #1;
    check("rdback_rvalid", {rvalid1, rvalid0}, 32'b01);
    check("rdback_rdata", rdata, 32'h1234);

    // Back-to-back alternating reads
    @(negedge clk);
    drive0(1'b1, 1'b0, 8'h30, '0, 1'b0);
    #1;
    check("b2b_gnt0", {gnt1, gnt0}, 32'b01);
    @(negedge clk);
    idle();
    drive1(1'b1, 1'b0, 8'h31, '0, 1'b0);
    #1;
    check("b2b_gnt1", {gnt1, gnt0}, 32'b10);
    check("b2b_rvalid0", {rvalid1, rvalid0}, 32'b01);
    check("b2b_rdata0", rdata, 32'h1111);
    @(negedge clk);
    idle();
    #1;
    check("b2b_rvalid1", {rvalid1, rvalid0}, 32'b10);
    check("b2b_rdata1", rdata, 32'h2222);

    // Reset lands before the edge that would return a granted read
    @(negedge clk);
    drive0(1'b1, 1'b0, 8'h05, '0, 1'b0);
    #1;
    check("rst_rd_gnt", {gnt1, gnt0}, 32'b01);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_rd_gnt_in_reset", {gnt1, gnt0}, 32'b01);
    check("rst_rd_state", state, 32'd0);
    @(negedge clk);
    #1;
    check("rst_rd_no_rvalid", {rvalid1, rvalid0}, 32'd0);
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    drive0(1'b1, 1'b1, 8'h50, 16'h0005, 1'b0);
    drive1(1'b1, 1'b1, 8'h51, 16'h0006, 1'b0);
    #1;
    check("post_rst_state", state, 32'd0);
    check("post_rst_gnt", {gnt1, gnt0}, 32'b01);

`ifdef MEM_ARBITER_PERF_CNT_EN
    // Saturation: requester 0 holds the lock while requester 1 waits
    @(negedge clk);
    drive0(1'b1, 1'b1, 8'h50, 16'h0005, 1'b1);
    repeat (70000) @(negedge clk);
    #1;
    check("sat_gnt", {gnt1, gnt0}, 32'b01);
    check("sat_wait1", wait_cnt1, 32'hFFFF);
`endif

    @(negedge clk);
    idle();
    #1;
    check("final_idle_gnt", {gnt1, gnt0}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
